// File: rtl/alu_operand_loader.sv
// alu_operand_loader: collects operand A (with opcode) then B, holds them on the ALU, captures and hands off the result
module alu_operand_loader #(
    parameter int EXEC_CYC = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic [2:0] in_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       alu_op,
    output logic       alu_s1,
    output logic       alu_s2,
    input  logic [8:0] alu_out,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [8:0] res_data,
    output logic [2:0] res_op,
    output logic [7:0] op_count
);
    typedef enum logic [1:0] {GET_A, GET_B, EXEC, HOLD} state_t;
    localparam logic [1:0] LAST = 2'(EXEC_CYC - 1);
    state_t     state;
    logic [1:0] exec_cnt;
    // operand words are only taken while collecting, never while reset is held
    assign in_ready = ~reset & (state == GET_A || state == GET_B);
    // sequencer: capture A/opcode, capture B, wait EXEC_CYC cycles, hold result until taken
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= GET_A;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= 1'b0;
            alu_s1    <= 1'b0;
            alu_s2    <= 1'b0;
            res_data  <= '0;
            res_op    <= '0;
            res_valid <= 1'b0;
            op_count  <= '0;
            exec_cnt  <= '0;
        end else begin
            case (state)
                GET_A: if (in_valid) begin
                    alu_a                    <= in_data;
                    {alu_op, alu_s1, alu_s2} <= in_op;
                    state                    <= GET_B;
                end
                GET_B: if (in_valid) begin
                    alu_b    <= in_data;
                    exec_cnt <= '0;
                    state    <= EXEC;
                end
                EXEC: begin
                    exec_cnt <= exec_cnt + 2'd1;
                    if (exec_cnt == LAST) begin
                        res_data  <= alu_out;
                        res_op    <= {alu_op, alu_s1, alu_s2};
                        res_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: if (res_ready) begin
                    res_valid <= 1'b0;
                    op_count  <= op_count + 8'd1;
                    state     <= GET_A;
                end
                default: state <= GET_A;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_operand_loader.sv
// tb_alu_operand_loader: directed checks of the operand loader with a behavioural ALU
module tb_alu_operand_loader;
    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready, res_valid, res_ready;
    logic [7:0] in_data, alu_a, alu_b, op_count;
    logic [2:0] in_op, res_op;
    logic       alu_op, alu_s1, alu_s2;
    logic [8:0] alu_out, res_data;
    logic       in_valid3, in_ready3, res_valid3, res_ready3;
    logic [7:0] in_data3, alu_a3, alu_b3, op_count3;
    logic [2:0] in_op3, res_op3;
    logic       alu_op3, alu_s13, alu_s23;
    logic [8:0] alu_out3, res_data3;
    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    function automatic logic [8:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'b000:  return {1'b0, a} + {1'b0, b};
            3'b001:  return {1'b0, a} - {1'b0, b};
            3'b010:  return {1'b0, a | b};
            3'b110:  return {1'b0, a & b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    assign alu_out  = alu(alu_a, alu_b, {alu_op, alu_s1, alu_s2});
    assign alu_out3 = alu(alu_a3, alu_b3, {alu_op3, alu_s13, alu_s23});

    alu_operand_loader dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_op(in_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_s1(alu_s1), .alu_s2(alu_s2), .alu_out(alu_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_op(res_op), .op_count(op_count)
    );

    alu_operand_loader #(.EXEC_CYC(3)) dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_data(in_data3), .in_op(in_op3), .alu_a(alu_a3), .alu_b(alu_b3),
        .alu_op(alu_op3), .alu_s1(alu_s13), .alu_s2(alu_s23), .alu_out(alu_out3),
        .res_valid(res_valid3), .res_ready(res_ready3), .res_data(res_data3),
        .res_op(res_op3), .op_count(op_count3)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; res_ready = 1'b0; in_data = '0; in_op = '0;
        in_valid3 = 1'b0; res_ready3 = 1'b0; in_data3 = '0; in_op3 = '0;
        step; step;
        chk("rst_in_ready", 16'(in_ready), 16'h0);
        chk("rst_res_valid", 16'(res_valid), 16'h0);
        chk("rst_op_count", 16'(op_count), 16'h0);
        chk("rst_alu_a", 16'(alu_a), 16'h0);
        chk("rst_res_data", 16'(res_data), 16'h0);
        reset = 1'b0;
        #1 chk("post_rst_in_ready", 16'(in_ready), 16'h1);
        step;
        in_valid3 = 1'b1; in_data3 = 8'hF0; in_op3 = 3'b110;
        step;
        chk("c3_a", 16'(alu_a3), 16'h00F0);
        in_data3 = 8'h3C;
        step;
        in_valid3 = 1'b0;
        chk("c3_b", 16'(alu_b3), 16'h003C);
        step;
        chk("c3_k1_valid", 16'(res_valid3), 16'h0);
        step;
        chk("c3_k2_valid", 16'(res_valid3), 16'h0);
        chk("c3_k2_a_stable", 16'(alu_a3), 16'h00F0);
        step;
        chk("c3_k3_valid", 16'(res_valid3), 16'h1);
        chk("c3_and_data", 16'(res_data3), 16'h0030);
        chk("c3_and_op", 16'(res_op3), 16'h0006);
        res_ready3 = 1'b1;
        step;
        res_ready3 = 1'b0;
        chk("c3_count", 16'(op_count3), 16'h1);
        chk("c3_release", 16'(res_valid3), 16'h0);
        in_valid = 1'b1; in_data = 8'hFF; in_op = 3'b000;
        step;
        chk("add_a", 16'(alu_a), 16'h00FF);
        chk("add_in_ready_b", 16'(in_ready), 16'h1);
        in_data = 8'h01;
        step;
        in_valid = 1'b0;
        chk("add_b", 16'(alu_b), 16'h0001);
        chk("add_exec_in_ready", 16'(in_ready), 16'h0);
        chk("add_exec_valid", 16'(res_valid), 16'h0);
        step;
        chk("add_valid", 16'(res_valid), 16'h1);
        chk("add_data", 16'(res_data), 16'h0100);
        chk("add_op", 16'(res_op), 16'h0000);
        res_ready = 1'b1;
        step;
        res_ready = 1'b0;
        chk("add_release", 16'(res_valid), 16'h0);
        chk("add_count", 16'(op_count), 16'h1);
        chk("add_in_ready", 16'(in_ready), 16'h1);
        in_valid = 1'b1; in_data = 8'h05; in_op = 3'b001;
        step;
        in_data = 8'h07;
        step;
        in_valid = 1'b0;
        step;
        chk("sub_data", 16'(res_data), 16'h01FE);
        chk("sub_op", 16'(res_op), 16'h0001);
        in_valid = 1'b1; in_data = 8'hAA; in_op = 3'b111;
        for (int i = 0; i < 5; i++) begin
            step;
            chk("sub_hold_data", 16'(res_data), 16'h01FE);
            chk("sub_hold_valid", 16'(res_valid), 16'h1);
            chk("sub_hold_in_ready", 16'(in_ready), 16'h0);
        end
        chk("sub_ignored_a", 16'(alu_a), 16'h0005);
        chk("sub_ignored_op", 16'({alu_op, alu_s1, alu_s2}), 16'h0001);
        in_valid = 1'b0; res_ready = 1'b1;
        step;
        chk("sub_count", 16'(op_count), 16'h2);
        step;
        chk("idle_ready_no_effect", 16'(op_count), 16'h2);
        res_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h11; in_op = 3'b010;
        step;
        in_valid = 1'b0; in_data = 8'h22;
        step;
        chk("gap1_in_ready", 16'(in_ready), 16'h1);
        chk("gap1_b", 16'(alu_b), 16'h0007);
        step;
        chk("gap2_b", 16'(alu_b), 16'h0007);
        chk("gap2_a", 16'(alu_a), 16'h0011);
        in_valid = 1'b1; in_data = 8'h33;
        step;
        in_valid = 1'b0;
        chk("gap_b", 16'(alu_b), 16'h0033);
        chk("gap_in_ready", 16'(in_ready), 16'h0);
        step;
        chk("gap_or_data", 16'(res_data), 16'h0033);
        chk("gap_or_op", 16'(res_op), 16'h0002);
        res_ready = 1'b1;
        step;
        res_ready = 1'b0;
        chk("gap_count", 16'(op_count), 16'h3);
        in_valid = 1'b1; in_data = 8'h40; in_op = 3'b000;
        step;
        in_data = 8'h02;
        step;
        in_valid = 1'b0; reset = 1'b1; res_ready = 1'b1;
        step;
        chk("rexec_valid", 16'(res_valid), 16'h0);
        chk("rexec_count", 16'(op_count), 16'h0);
        chk("rexec_in_ready_rst", 16'(in_ready), 16'h0);
        reset = 1'b0; res_ready = 1'b0;
        #1 chk("rexec_in_ready", 16'(in_ready), 16'h1);
        step;
        chk("rexec_no_result", 16'(res_valid), 16'h0);
        chk("rexec_data", 16'(res_data), 16'h0);
        res_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 255; i++) begin
            in_data = 8'(i);
            repeat (4) step;
        end
        chk("wrap_255", 16'(op_count), 16'h00FF);
        repeat (4) step;
        chk("wrap_0", 16'(op_count), 16'h0000);
        in_valid = 1'b0; res_ready = 1'b0;
        step;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/alu_operand_loader.md
ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

Interface
REQ-001 The block SHALL have parameter EXEC_CYC, default 1, giving the number of cycles that operands are held stable on the ALU before the result is captured; legal range 1..4.
REQ-002 The port clk SHALL be an input, 1 bit wide: the single clock; all state updates on the rising edge.
REQ-003 The port reset SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-004 The port in_valid SHALL be an input, 1 bit wide: the upstream operand word is valid.
REQ-005 The port in_ready SHALL be an output, 1 bit wide: the block accepts an operand word this cycle.
REQ-006 The port in_data SHALL be an input, 8 bits wide: the operand word; A first, then B.
REQ-007 The port in_op SHALL be an input, 3 bits wide: the opcode {Op,S1,S2}; it is sampled only with operand A.
REQ-008 The ports alu_a and alu_b SHALL be outputs, 8 bits wide each: registered operands driven to the ALU.
REQ-009 The ports alu_op, alu_s1 and alu_s2 SHALL be outputs, 1 bit wide each: the registered opcode bits driven to the ALU.
REQ-010 The port alu_out SHALL be an input, 9 bits wide: the combinational ALU result.
REQ-011 The port res_valid SHALL be an output, 1 bit wide: res_data and res_op are valid.
REQ-012 The port res_ready SHALL be an input, 1 bit wide: downstream accepts the result.
REQ-013 The port res_data SHALL be an output, 9 bits wide: the captured ALU result.
REQ-014 The port res_op SHALL be an output, 3 bits wide: the opcode that produced res_data.
REQ-015 The port op_count SHALL be an output, 8 bits wide: the count of completed result handshakes.

Function
REQ-016 The FSM SHALL have the states GET_A, GET_B, EXEC and HOLD; after reset the state is GET_A.
REQ-017 in_ready SHALL be 1 exactly in GET_A and GET_B, and 0 in EXEC and HOLD.
REQ-018 In GET_A, when in_valid=1, the block SHALL load alu_a<=in_data and {alu_op,alu_s1,alu_s2}<=in_op, then go to GET_B.
REQ-019 In GET_B, when in_valid=1, the block SHALL load alu_b<=in_data, clear the exec counter, then go to EXEC.
REQ-020 In GET_A and GET_B, when in_valid=0, the block SHALL hold its state and all registers.
REQ-021 in_valid asserted while in_ready=0 SHALL be ignored, with no capture and no state change.
REQ-022 In EXEC, the exec counter SHALL increment each cycle; on the cycle the counter equals EXEC_CYC-1, the block SHALL load res_data<=alu_out and res_op<=opcode, set res_valid<=1 and go to HOLD.
REQ-023 Latency SHALL be as follows: if operand B is accepted at edge k, res_valid rises at edge k+EXEC_CYC.
REQ-024 alu_a, alu_b and the opcode outputs SHALL stay stable from the B-accept edge through HOLD.
REQ-025 In HOLD, res_valid SHALL be 1, and res_data and res_op SHALL be stable until res_ready=1 is sampled.
REQ-026 In HOLD with res_ready=1, the block SHALL clear res_valid, increment op_count (modulo 256; 255 wraps to 0) and go to GET_A.
REQ-027 res_ready while res_valid=0 SHALL have no effect.
REQ-028 There SHALL be no overlap: a new operand A is accepted no earlier than the cycle after the result handshake.
REQ-029 res_data SHALL be alu_out passed unmodified in all 9 bits; the block SHALL NOT do any width change or sign handling.

Reset
REQ-030 While reset=1 at a clock edge, the block SHALL set: state<=GET_A, alu_a<=0, alu_b<=0, alu_op/alu_s1/alu_s2<=0, res_data<=0, res_op<=0, res_valid<=0, op_count<=0, exec counter<=0.
REQ-031 in_ready SHALL be 0 while reset is high, and 1 in the first cycle after reset deasserts.
REQ-032 Reset asserted in any state, including mid-EXEC or in HOLD with res_valid=1, SHALL drop the pending transaction with no result and no op_count increment.
REQ-033 Reset SHALL take priority over in_valid and res_ready in the same cycle.

Verification
REQ-034 Add with carry: op 000, A=8'hFF, B=8'h01, EXEC_CYC=1 -> res_valid one cycle after B is accepted, res_data=9'h100, res_op=3'b000.
REQ-035 Subtract: op 001, A=8'h05, B=8'h07 -> res_data=9'h1FE; with res_ready held 0 for 5 cycles, res_data stays stable and in_ready=0 throughout.
REQ-036 AND with EXEC_CYC=3: op 110, A=8'hF0, B=8'h3C -> res_valid rises 3 cycles after B is accepted, res_data=9'h030.
REQ-037 Upstream gaps: in_valid toggled 1,0,0,1 -> exactly two words are captured, with no spurious advance during the gap cycles.
REQ-038 Reset in EXEC: reset pulsed one cycle after B is accepted -> res_valid never rises, op_count=0, and in_ready=1 in the cycle after reset.
REQ-039 Counter wrap: 256 back-to-back transactions with res_ready tied to 1 -> op_count returns to 8'h00.
